// File: rtl/rgb_mask_unit.sv
// rgb_mask_unit: per-channel ALU that combines an RGB pixel with a ROM mask
// and registers the result. One-cycle latency from inputs to RGBout. There is
// no backpressure: Mode=1 loads RGBout on every rising edge, Mode=0 holds it.
//
// Ports:
//   CLK      rising-edge clock
//   RST      asynchronous, active-high reset; clears RGBout
//   Mode     1 = compute and load RGBout, 0 = hold RGBout
//   Address  mask ROM index (0..15)
//   RGBin    input pixel, [23:16]=R [15:8]=G [7:0]=B
//   Op       per-channel operation select
//   RGBout   registered result, same channel packing as RGBin
module rgb_mask_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Mode,
  input  logic [3:0]  Address,
  input  logic [23:0] RGBin,
  input  logic [2:0]  Op,
  output logic [23:0] RGBout
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_ADDS = 3'b011,
    OP_SUBS = 3'b100,
    OP_INCS = 3'b101,
    OP_DECS = 3'b110,
    OP_ROL  = 3'b111
  } op_t;

  // Constant mask ROM. Every entry carries the same byte in R, G and B, so
  // only the byte is stored and it is replicated across the channels.
  function automatic logic [7:0] mask_byte(input logic [3:0] idx);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'h00;
      4'd1:    b = 8'h11;
      4'd2:    b = 8'h22;
      4'd3:    b = 8'h33;
      4'd4:    b = 8'h44;
      4'd5:    b = 8'h55;
      4'd6:    b = 8'h66;
      4'd7:    b = 8'h77;
      4'd8:    b = 8'h88;
      4'd9:    b = 8'h99;
      4'd10:   b = 8'hA6;
      4'd11:   b = 8'hBB;
      4'd12:   b = 8'hCC;
      4'd13:   b = 8'hDD;
      4'd14:   b = 8'hD3;
      default: b = 8'hFF;
    endcase
    return b;
  endfunction

  // One 8-bit channel. Saturating ops use a 9-bit intermediate so the carry
  // or borrow decides the clamp and never leaks into a neighbouring channel.
  function automatic logic [7:0] channel_op(input op_t op, input logic [7:0] x,
                                            input logic [7:0] m);
    logic [8:0] wide;
    logic [7:0] r;
    wide = 9'd0;
    case (op)
      OP_AND:  r = x & m;
      OP_OR:   r = x | m;
      OP_XOR:  r = x ^ m;
      OP_ADDS: begin
        wide = {1'b0, x} + {1'b0, m};
        r    = wide[8] ? 8'hFF : wide[7:0];
      end
      OP_SUBS: begin
        wide = {1'b0, x} - {1'b0, m};
        r    = wide[8] ? 8'h00 : wide[7:0];
      end
      OP_INCS: r = (x == 8'hFF) ? 8'hFF : x + 8'd1;
      OP_DECS: r = (x == 8'h00) ? 8'h00 : x - 8'd1;
      default: r = {x[6:0], x[7]};
    endcase
    return r;
  endfunction

  logic [7:0]  mask;
  logic [23:0] result;

  assign mask = mask_byte(Address);

  always_comb begin
    result = 24'h000000;
    for (int ch = 0; ch < 3; ch++) begin
      result[ch*8 +: 8] = channel_op(op_t'(Op), RGBin[ch*8 +: 8], mask);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RGBout <= 24'h000000;
    end else if (Mode) begin
      RGBout <= result;
    end
  end

endmodule

// File: tb/tb_rgb_mask_unit.sv
// Testbench for rgb_mask_unit: scoreboard of expected RGBout values, pushed
// when a load or hold edge is driven and popped after that edge.
module tb_rgb_mask_unit;

  logic        CLK;
  logic        RST;
  logic        Mode;
  logic [3:0]  Address;
  logic [23:0] RGBin;
  logic [2:0]  Op;
  logic [23:0] RGBout;

  int checks   = 0;
  int failures = 0;

  logic [23:0] exp_q[$];

  localparam logic [7:0] MASK_TB [16] = '{
    8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
    8'h88, 8'h99, 8'hA6, 8'hBB, 8'hCC, 8'hDD, 8'hD3, 8'hFF
  };

  rgb_mask_unit dut (
    .CLK     (CLK),
    .RST     (RST),
    .Mode    (Mode),
    .Address (Address),
    .RGBin   (RGBin),
    .Op      (Op),
    .RGBout  (RGBout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model built from integer arithmetic and clamps.
  function automatic logic [7:0] ref_ch(input int op, input int x, input int m);
    int v;
    case (op)
      0: v = x & m;
      1: v = x | m;
      2: v = x ^ m;
      3: begin v = x + m; if (v > 255) v = 255; end
      4: begin v = x - m; if (v < 0) v = 0; end
      5: begin v = x + 1; if (v > 255) v = 255; end
      6: begin v = x - 1; if (v < 0) v = 0; end
      default: v = ((x * 2) % 256) + (x / 128);
    endcase
    return v[7:0];
  endfunction

  function automatic logic [23:0] ref_pix(input int op, input int addr, input logic [23:0] p);
    int m;
    m = int'(MASK_TB[addr]);
    return {ref_ch(op, int'(p[23:16]), m), ref_ch(op, int'(p[15:8]), m),
            ref_ch(op, int'(p[7:0]), m)};
  endfunction

  // Drive inputs on the falling edge, then return 1 time unit after the
  // following rising edge so RGBout is sampled away from the edge.
  task automatic step(input logic md, input logic [3:0] a, input logic [23:0] px,
                      input logic [2:0] o);
    @(negedge CLK);
    Mode    = md;
    Address = a;
    RGBin   = px;
    Op      = o;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [23:0] e;
    RST = 1'b1; Mode = 1'b1; Address = 4'd15; RGBin = 24'h123456; Op = 3'd1;
    #1;
    exp_q.push_back(24'h000000);
    e = exp_q.pop_front();
    checks++;
    if (RGBout !== e) begin
      failures++;
      $display("FAIL reset_initial got=%06h exp=%06h", RGBout, e);
    end
    // Reset must dominate Mode across a clock edge.
    exp_q.push_back(24'h000000);
    step(1'b1, 4'd15, 24'h123456, 3'd1);
    e = exp_q.pop_front();
    checks++;
    if (RGBout !== e) begin
      failures++;
      $display("FAIL reset_over_mode got=%06h exp=%06h", RGBout, e);
    end
    @(negedge CLK);
    RST = 1'b0;
    Mode = 1'b0;
  endtask

  task automatic test_ops_addr10();
    logic [23:0] tbl [8] = '{24'h808202, 24'hA7E7E6, 24'h2765E4, 24'hFFFFE8,
                             24'h001D00, 24'h82C443, 24'h80C241, 24'h038784};
    logic [23:0] e;
    for (int op = 0; op < 8; op++) begin
      exp_q.push_back(tbl[op]);
      step(1'b1, 4'd10, 24'h81C342, op[2:0]);
      e = exp_q.pop_front();
      checks++;
      if (RGBout !== e) begin
        failures++;
        $display("FAIL addr10_op%0d got=%06h exp=%06h", op, RGBout, e);
      end
      // Mode drops: result must hold even with different inputs.
      exp_q.push_back(tbl[op]);
      step(1'b0, 4'd3, 24'hFFFFFF, 3'(op + 1));
      e = exp_q.pop_front();
      checks++;
      if (RGBout !== e) begin
        failures++;
        $display("FAIL addr10_hold_op%0d got=%06h exp=%06h", op, RGBout, e);
      end
    end
  endtask

  task automatic test_ops_addr14();
    logic [23:0] tbl [8] = '{24'h434143, 24'hF3F7F7, 24'hB0B6B4, 24'hFFFFFF,
                             24'h000000, 24'h646668, 24'h626466, 24'hC6CACE};
    logic [23:0] e;
    for (int op = 0; op < 8; op++) begin
      exp_q.push_back(tbl[op]);
      step(1'b1, 4'd14, 24'h636567, op[2:0]);
      e = exp_q.pop_front();
      checks++;
      if (RGBout !== e) begin
        failures++;
        $display("FAIL addr14_op%0d got=%06h exp=%06h", op, RGBout, e);
      end
    end
  endtask

  task automatic test_saturation();
    logic [3:0]  a   [3] = '{4'd0, 4'd0, 4'd15};
    logic [23:0] px  [3] = '{24'hFF0080, 24'hFF0080, 24'h010203};
    logic [2:0]  o   [3] = '{3'd5, 3'd6, 3'd3};
    logic [23:0] tbl [3] = '{24'hFF0181, 24'hFE007F, 24'hFFFFFF};
    logic [23:0] e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(tbl[i]);
      step(1'b1, a[i], px[i], o[i]);
      e = exp_q.pop_front();
      checks++;
      if (RGBout !== e) begin
        failures++;
        $display("FAIL sat_%0d got=%06h exp=%06h", i, RGBout, e);
      end
    end
  endtask

  task automatic test_hold();
    logic [23:0] e;
    exp_q.push_back(24'h808202);
    step(1'b1, 4'd10, 24'h81C342, 3'd0);
    e = exp_q.pop_front();
    checks++;
    if (RGBout !== e) begin
      failures++;
      $display("FAIL hold_load got=%06h exp=%06h", RGBout, e);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(24'h808202);
      step(1'b0, 4'(i * 3 + 1), 24'h0F0F0F + 24'(i * 24'h111111), 3'(i + 2));
      e = exp_q.pop_front();
      checks++;
      if (RGBout !== e) begin
        failures++;
        $display("FAIL hold_edge%0d got=%06h exp=%06h", i, RGBout, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] e;
    exp_q.push_back(24'h808202);
    step(1'b1, 4'd10, 24'h81C342, 3'd0);
    e = exp_q.pop_front();
    checks++;
    if (RGBout !== e) begin
      failures++;
      $display("FAIL async_preload got=%06h exp=%06h", RGBout, e);
    end
    // Raise reset midway between edges; RGBout must clear without a clock.
    #1;
    RST = 1'b1;
    #1;
    exp_q.push_back(24'h000000);
    e = exp_q.pop_front();
    checks++;
    if (RGBout !== e) begin
      failures++;
      $display("FAIL async_clear got=%06h exp=%06h", RGBout, e);
    end
    @(negedge CLK);
    RST = 1'b0;
    // First edge after release with Mode=1 loads normally.
    exp_q.push_back(24'h2765E4);
    step(1'b1, 4'd10, 24'h81C342, 3'd2);
    e = exp_q.pop_front();
    checks++;
    if (RGBout !== e) begin
      failures++;
      $display("FAIL async_release_load got=%06h exp=%06h", RGBout, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] e;
    logic [23:0] px;
    logic [3:0]  a;
    logic [2:0]  o;
    for (int i = 0; i < 40; i++) begin
      px = 24'($urandom);
      a  = 4'($urandom_range(0, 15));
      o  = 3'($urandom_range(0, 7));
      if (i < 8) begin
        // Channel extremes to stress the clamps on every op.
        px = {8'hFF, 8'h00, 8'h80};
        o  = 3'(i);
      end
      exp_q.push_back(ref_pix(int'(o), int'(a), px));
      step(1'b1, a, px, o);
      e = exp_q.pop_front();
      checks++;
      if (RGBout !== e) begin
        failures++;
        $display("FAIL b2b_%0d op=%0d addr=%0d in=%06h got=%06h exp=%06h",
                 i, o, a, px, RGBout, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ops_addr10();
    test_ops_addr14();
    test_saturation();
    test_hold();
    test_async_reset();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
